// File: rtl/rom_reader.sv
// rom_reader: walks an address range of an async-read ROM and streams
// each registered word out on a valid/ready channel, tagging the last one.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - command strobe, taken only while idle
//   start_addr      - first ROM address of the command
//   count           - words to read, 0 .. 2^ADDR_W
//   rom_oeb         - ROM output enable, active-low (low only in FETCH)
//   rom_addr        - ROM address
//   rom_data        - ROM read data, combinational while rom_oeb=0
//   out_valid/ready - downstream handshake
//   out_data        - registered ROM word
//   out_last        - final word of the command
//   busy            - command in progress
//   done            - one-cycle pulse after the last word is taken
//   checksum        - running sum of delivered words (optional)
//
// Optional feature: define ROM_READER_CHECKSUM_EN to add the checksum
// output and its accumulator.

module rom_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rom_oeb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef ROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              accept;
  logic              fire;

  assign accept   = (state == S_IDLE) && start;
  assign fire     = out_valid && out_ready;
  assign rom_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    rom_oeb = 1'b1;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          // A zero-length command still reports completion.
          state_n = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rom_oeb = 1'b0;
        state_n = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_n = out_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && (count != '0)) begin
            addr      <= start_addr;
            remaining <= count;
          end
        end
        S_FETCH: begin
          out_data  <= rom_data;
          out_last  <= (remaining == ONE);
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - ONE;
            // Address wraps naturally at 2^ADDR_W; keep it on the last
            // word so rom_addr holds its final value while idle.
            if (!out_last) begin
              addr <= addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (fire) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: scoreboard bench for rom_reader.
// Driver queues expected addresses/words; a negedge monitor checks them.

module tb_rom_reader;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          rom_oeb;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef ROM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rom_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .rom_oeb    (rom_oeb),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef ROM_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  assign rom_data = rom_oeb ? 16'hBAD0 : mem[rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [AW-1:0] q_addr [$];
  logic [DW:0]   q_word [$];

  bit            mon_en = 0;
  bit            rand_ready = 0;
  bit            model_busy = 0;
  bit            exp_done = 0;
  bit            nxt_done;
  bit            stall = 0;
  logic [AW+DW:0] stall_v;
  logic [AW-1:0] m_a;
  logic [DW:0]   m_w;
  logic [DW-1:0] sum = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_oeb === 1'b0) begin
        if (q_addr.size() == 0) begin
          chk("unexpected_fetch", 1, 0);
        end else begin
          m_a = q_addr.pop_front();
          chk("rom_addr", 32'(rom_addr), 32'(m_a));
        end
      end
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_oeb", 32'(rom_oeb), 1);
        chk("stall_hold", 32'({rom_addr, out_last, out_data}),
            32'(stall_v));
      end
      chk("busy", 32'(busy), 32'(model_busy));
      if (exp_done || done) begin
        chk("done", 32'(done), 32'(exp_done));
      end
`ifdef ROM_READER_CHECKSUM_EN
      if (done) begin
        chk("checksum", 32'(checksum), 32'(sum));
      end
`endif
      nxt_done = 0;
      if (rst) begin
        model_busy = 0;
        stall = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (q_word.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            m_w = q_word.pop_front();
            chk("out_word", 32'({out_last, out_data}), 32'(m_w));
            sum = sum + m_w[DW-1:0];
            nxt_done = m_w[DW];
          end
        end
        if (exp_done) begin
          model_busy = 0;
        end else if (start && !model_busy) begin
          model_busy = 1;
          sum = '0;
          if (count == 0) nxt_done = 1;
        end
        stall = out_valid && !out_ready;
      end
      stall_v = {rom_addr, out_last, out_data};
      exp_done = nxt_done;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [AW-1:0] sa, input logic [AW:0] cnt);
    start = 1'b1;
    start_addr = sa;
    count = cnt;
    for (int i = 0; i < int'(cnt); i++) begin
      logic [AW-1:0] a;
      a = AW'((int'(sa) + i) % (2**AW));
      q_addr.push_back(a);
      q_word.push_back({(i == int'(cnt) - 1), mem[a]});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || q_word.size() != 0) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= maxc) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_reset();
    chk("rst_oeb", 32'(rom_oeb), 1);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    count = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem[i] = 16'h1000 + 16'(i);
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    mon_en = 1;

    // Full sweep at full rate; done lands 2*count+1 negedges after accept.
    out_ready = 1'b1;
    issue(0, 8);
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!done && j < 40);
    chk("sweep_latency", 32'(j), 17);
`ifdef ROM_READER_CHECKSUM_EN
    chk("checksum_801c", 32'(checksum), 32'h801C);
`endif
    @(posedge clk);
    #1;
    wait_idle(50);

    // Wrap-around, plus first-word timing.
    issue(6, 4);
    @(negedge clk);
    chk("first_fetch_oeb", 32'(rom_oeb), 0);
    chk("first_fetch_valid", 32'(out_valid), 0);
`ifdef ROM_READER_CHECKSUM_EN
    chk("checksum_clear", 32'(checksum), 0);
`endif
    @(negedge clk);
    chk("first_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    wait_idle(50);

    // Back-pressure on word 2 with a start attempt that must be ignored.
    issue(2, 4);
    j = 0;
    while (q_word.size() > 3 && j < 20) begin
      @(posedge clk);
      #1;
      j++;
    end
    if (j >= 20) chk("bp_timeout", 1, 0);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = 5;
    count = 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_valid_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_idle(50);

    // Zero-length command; a start while in DONE is ignored.
    issue(4, 0);
    start = 1'b1;
    start_addr = 3;
    count = 2;
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_idle_busy", 32'(busy), 0);
    chk("zero_idle_done", 32'(done), 0);
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;

    // Reset while a word is waiting in OUT.
    out_ready = 1'b0;
    issue(1, 3);
    j = 0;
    while (!out_valid && j < 20) begin
      @(posedge clk);
      #1;
      j++;
    end
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_addr.delete();
    q_word.delete();
    check_reset();
    @(negedge clk);
    chk("post_rst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3, 3);
    wait_idle(50);

    // Random commands, random ROM image, random back-pressure.
    rand_ready = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 16'($urandom);
      end
      issue(AW'($urandom_range(0, 2**AW - 1)),
            (AW+1)'($urandom_range(0, 2**AW)));
      wait_idle(200);
      @(posedge clk);
      #1;
    end
    rand_ready = 0;
    repeat (3) @(posedge clk);
    #1;

    chk("queues_empty", 32'(q_word.size() + q_addr.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
